ncc_result_writeback: RTL and testbench

Downstream of the frame-level template/window sequencer. It captures each per-set NCC result (greatest NCC log2 value, greatest window index, set number) and buffers it in a small FIFO. Each result is serialised into three 32-bit memory writes over a req/grant handshake. At frame end it writes one status word and pulses a completion flag.

---
 rtl/ncc_result_writeback.sv | 171 +++++++++++++++++
 tb/tb_ncc_result_writeback.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncc_result_writeback.sv
// Buffers per-set NCC results in a small FIFO and serialises each one into three
// 32-bit memory writes, followed by a per-frame status word and a completion pulse.
module ncc_result_writeback #(
  parameter int                DEPTH         = 4,
  parameter int                ADDR_W        = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter int                STATUS_OFFSET = 450
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              result_valid,
  input  logic [7:0]        set_idx,
  input  logic [63:0]       ncc_log2,
  input  logic [8:0]        window_index,
  input  logic              frame_done,
  output logic              mem_req,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_grant,
  output logic              frame_written,
  output logic              overflow
);

  typedef enum logic [2:0] {IDLE, W0, W1, W2, STAT, PULSE} state_t;

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = 8 + 9 + 64;
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(32'(BASE_ADDR) + 32'(STATUS_OFFSET));

  logic [ENTRY_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;

  state_t             state;
  state_t             next_state;
  logic               req_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [31:0]        wdata_n;
  logic               fw_n;

  logic [7:0]         written_cnt;
  logic [7:0]         dropped_cnt;
  logic               frame_pending;

  logic               pop;
  logic               push;
  logic               drop;
  logic [ENTRY_W-1:0] head;
  logic [7:0]         head_set;
  logic [8:0]         head_win;
  logic [63:0]        head_ncc;
  logic [ADDR_W-1:0]  rec_addr;

  assign mem_rd_wr = 1'b1;

  // The head entry stays in the FIFO until its last word is accepted, so a push
  // into a full FIFO is only safe in the cycle that retires that head.
  assign pop  = (state == W2) && mem_grant;
  assign push = result_valid && ((count < (PTR_W+1)'(DEPTH)) || pop);
  assign drop = result_valid && !push;

  assign head     = fifo_mem[rd_ptr];
  assign head_set = head[80:73];
  assign head_win = head[72:64];
  assign head_ncc = head[63:0];
  assign rec_addr = ADDR_W'(32'(BASE_ADDR) + 32'(head_set) * 32'd3);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {set_idx, window_index, ncc_log2};
  end

  always_comb begin
    next_state = state;
    req_n      = mem_req;
    addr_n     = mem_addr;
    wdata_n    = mem_wdata;
    fw_n       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          next_state = W0;
          req_n      = 1'b1;
          addr_n     = rec_addr;
          wdata_n    = {7'b0, head_win, 8'b0, head_set};
        end else if (frame_pending) begin
          next_state = STAT;
          req_n      = 1'b1;
          addr_n     = STAT_ADDR;
          wdata_n    = {overflow, 7'b0, dropped_cnt, 8'b0, written_cnt};
        end
      end
      W0: begin
        if (mem_grant) begin
          next_state = W1;
          addr_n     = mem_addr + ADDR_W'(1);
          wdata_n    = head_ncc[63:32];
        end
      end
      W1: begin
        if (mem_grant) begin
          next_state = W2;
          addr_n     = mem_addr + ADDR_W'(1);
          wdata_n    = head_ncc[31:0];
        end
      end
      W2: begin
        if (mem_grant) begin
          next_state = IDLE;
          req_n      = 1'b0;
        end
      end
      STAT: begin
        if (mem_grant) begin
          next_state = PULSE;
          req_n      = 1'b0;
          fw_n       = 1'b1;
        end
      end
      PULSE: next_state = IDLE;
      default: begin
        next_state = IDLE;
        req_n      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      frame_written <= 1'b0;
      overflow      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      written_cnt   <= '0;
      dropped_cnt   <= '0;
      frame_pending <= 1'b0;
    end else begin
      state         <= next_state;
      mem_req       <= req_n;
      mem_addr      <= addr_n;
      mem_wdata     <= wdata_n;
      frame_written <= fw_n;

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

      // A drop landing in the PULSE cycle belongs to the next frame's tally.
      if (state == PULSE) begin
        written_cnt   <= '0;
        dropped_cnt   <= {7'b0, drop};
        overflow      <= drop;
        frame_pending <= 1'b0;
      end else begin
        if (pop && (written_cnt != 8'hFF)) written_cnt <= written_cnt + 8'd1;
        if (drop) begin
          overflow <= 1'b1;
          if (dropped_cnt != 8'hFF) dropped_cnt <= dropped_cnt + 8'd1;
        end
        if (frame_done) frame_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ncc_result_writeback.sv
// Scoreboard bench for ncc_result_writeback: stimulus predicts the stream of memory
// writes into a queue, and a negedge monitor checks every accepted word against it.
module tb_ncc_result_writeback;

  localparam int          DEPTH     = 4;
  localparam int          BASE      = 0;
  localparam logic [15:0] STAT_ADDR = 16'(BASE + 450);

  logic        clk = 1'b0;
  logic        rst;
  logic        result_valid;
  logic [7:0]  set_idx;
  logic [63:0] ncc_log2;
  logic [8:0]  window_index;
  logic        frame_done;
  logic        mem_req;
  logic        mem_rd_wr;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_grant;
  logic        frame_written;
  logic        overflow;

  ncc_result_writeback dut (
    .clk           (clk),
    .rst           (rst),
    .result_valid  (result_valid),
    .set_idx       (set_idx),
    .ncc_log2      (ncc_log2),
    .window_index  (window_index),
    .frame_done    (frame_done),
    .mem_req       (mem_req),
    .mem_rd_wr     (mem_rd_wr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_grant     (mem_grant),
    .frame_written (frame_written),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks    = 0;
  int  fails     = 0;
  int  fw_seen   = 0;
  int  occ       = 0;
  int  frame_acc = 0;
  int  frame_drop = 0;
  bit  pending   = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_record(input logic [7:0] s, input logic [8:0] w, input logic [63:0] n);
    int a;
    a = BASE + 3 * int'(s);
    exp_q.push_back('{16'(a),     {7'b0, w, 8'b0, s}});
    exp_q.push_back('{16'(a + 1), n[63:32]});
    exp_q.push_back('{16'(a + 2), n[31:0]});
  endfunction

  function automatic logic [31:0] model_status();
    int wr;
    int dr;
    wr = (frame_acc > 255) ? 255 : frame_acc;
    dr = (frame_drop > 255) ? 255 : frame_drop;
    return {(frame_drop != 0), 7'b0, 8'(dr), 8'b0, 8'(wr)};
  endfunction

  // occ is the number of entries the bench knows are held; pushes are only issued
  // while nothing drains, except where pop_now marks a known same-cycle retire.
  task automatic apply_stimulus(input bit rv, input logic [7:0] s, input logic [8:0] w,
                                input logic [63:0] n, input bit fd, input bit pop_now);
    result_valid = rv;
    set_idx      = s;
    window_index = w;
    ncc_log2     = n;
    frame_done   = fd;
    if (rv) begin
      if (occ < DEPTH || pop_now) begin
        model_record(s, w, n);
        frame_acc++;
        if (!pop_now) occ++;
      end else begin
        frame_drop++;
      end
    end
    if (fd && !pending) begin
      pending = 1;
      exp_q.push_back('{STAT_ADDR, model_status()});
      frame_acc  = 0;
      frame_drop = 0;
    end
    tick();
    result_valid = 1'b0;
    frame_done   = 1'b0;
  endtask

  task automatic wait_frame_written(input int budget, input bit rand_grant);
    int start;
    int i;
    start = fw_seen;
    i = 0;
    while (fw_seen == start && i < budget) begin
      if (rand_grant) mem_grant = 1'($urandom_range(0, 1));
      tick();
      i++;
    end
    if (fw_seen == start) begin
      checks++;
      fails++;
      $display("[TB] FAIL frame_written timeout: got none within %0d cycles, expected a pulse", budget);
    end
    pending = 0;
    occ     = 0;
  endtask

  // Monitor: checks word hold during stalls and each accepted word against the queue.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_addr;
  logic [31:0] prev_data;
  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_output("stall mem_req", mem_req, 1);
        check_output("stall mem_addr", mem_addr, prev_addr);
        check_output("stall mem_wdata", mem_wdata, prev_data);
      end
      if (frame_written) fw_seen++;
      if (mem_req && mem_grant) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected write: got addr %0h data %0h, expected no write", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check_output("write addr", mem_addr, e.addr);
          check_output("write data", mem_wdata, e.data);
        end
      end
      prev_stall = mem_req && !mem_grant;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;
    int n;
    rst = 1'b1; result_valid = 1'b0; frame_done = 1'b0; mem_grant = 1'b0;
    set_idx = '0; window_index = '0; ncc_log2 = '0;
    tick(); tick();
    rst = 1'b0;
    check_output("reset mem_req", mem_req, 0);
    check_output("reset mem_addr", mem_addr, 0);
    check_output("reset mem_wdata", mem_wdata, 0);
    check_output("reset frame_written", frame_written, 0);
    check_output("reset overflow", overflow, 0);
    check_output("mem_rd_wr", mem_rd_wr, 1);

    $display("[TB] single record, grant held high");
    mem_grant = 1'b1;
    apply_stimulus(1, 8'd5, 9'h1A3, 64'h0123_4567_89AB_CDEF, 0, 0);
    check_output("latency t+1 mem_req", mem_req, 0);
    tick();
    check_output("latency t+2 mem_req", mem_req, 1);
    check_output("latency t+2 mem_addr", mem_addr, 16'(BASE + 15));
    check_output("latency t+2 mem_wdata", mem_wdata, 32'h01A3_0005);
    tick();
    check_output("t+3 mem_addr", mem_addr, 16'(BASE + 16));
    tick();
    check_output("t+4 mem_addr", mem_addr, 16'(BASE + 17));
    tick();
    check_output("t+5 mem_req", mem_req, 0);
    occ = 0;

    $display("[TB] grant stall in W1");
    apply_stimulus(1, 8'd7, 9'h055, 64'hFEDC_BA98_7654_3210, 0, 0);
    tick();
    tick();
    mem_grant = 1'b0;
    repeat (7) tick();
    check_output("stall W1 addr", mem_addr, 16'(BASE + 22));
    mem_grant = 1'b1;
    repeat (4) tick();
    occ = 0;
    apply_stimulus(0, 0, 0, 0, 1, 0);
    wait_frame_written(100, 0);
    check_output("queue empty after frame A", exp_q.size(), 0);

    $display("[TB] overflow");
    mem_grant = 1'b0;
    for (int i = 0; i < 6; i++)
      apply_stimulus(1, 8'(10 + i), 9'($urandom), {$urandom, $urandom}, 0, 0);
    tick();
    check_output("overflow set", overflow, 1);
    start = fw_seen;
    apply_stimulus(0, 0, 0, 0, 1, 0);
    mem_grant = 1'b1;
    wait_frame_written(200, 0);
    repeat (3) tick();
    check_output("frame_written once", fw_seen - start, 1);
    check_output("overflow cleared", overflow, 0);
    check_output("queue empty after overflow", exp_q.size(), 0);

    $display("[TB] push into full FIFO on retire");
    mem_grant = 1'b0;
    for (int i = 0; i < 4; i++)
      apply_stimulus(1, 8'(40 + i), 9'($urandom), {$urandom, $urandom}, 0, 0);
    repeat (3) tick();
    mem_grant = 1'b1;
    tick();
    tick();
    apply_stimulus(1, 8'd149, 9'h1FF, 64'hA5A5_5A5A_0F0F_F0F0, 0, 1);
    check_output("no overflow on retire push", overflow, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    wait_frame_written(200, 0);
    check_output("queue empty after retire push", exp_q.size(), 0);

    $display("[TB] result and repeat frame_done during status");
    mem_grant = 1'b0;
    for (int i = 0; i < 3; i++)
      apply_stimulus(1, 8'(60 + i), 9'($urandom), {$urandom, $urandom}, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    mem_grant = 1'b1;
    n = 0;
    while (!(mem_req && mem_addr == STAT_ADDR) && n < 100) begin
      tick();
      n++;
    end
    check_output("status request reached", (mem_req && mem_addr == STAT_ADDR), 1);
    start = fw_seen;
    apply_stimulus(1, 8'd99, 9'h0AB, 64'h1111_2222_3333_4444, 1, 0);
    wait_frame_written(50, 0);
    repeat (8) tick();
    check_output("single pulse for repeat frame_done", fw_seen - start, 1);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    wait_frame_written(100, 0);
    check_output("queue empty after status-time push", exp_q.size(), 0);

    $display("[TB] reset mid-W1");
    mem_grant = 1'b0;
    apply_stimulus(1, 8'd20, 9'h123, 64'hDEAD_BEEF_CAFE_F00D, 0, 0);
    tick();
    mem_grant = 1'b1;
    tick();
    mem_grant = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    occ = 0; frame_acc = 0; frame_drop = 0; pending = 0;
    check_output("post-reset mem_req", mem_req, 0);
    check_output("post-reset mem_addr", mem_addr, 0);
    check_output("post-reset mem_wdata", mem_wdata, 0);
    check_output("post-reset overflow", overflow, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    mem_grant = 1'b1;
    wait_frame_written(100, 0);
    check_output("queue empty after reset frame", exp_q.size(), 0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 8; f++) begin
      bit fd_sent;
      mem_grant = 1'b0;
      fd_sent = 0;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        bit fd;
        fd = (i == n - 1) && ($urandom_range(0, 1) == 1);
        apply_stimulus(1, 8'($urandom_range(0, 149)), 9'($urandom), {$urandom, $urandom}, fd, 0);
        if (fd) fd_sent = 1;
        if ($urandom_range(0, 2) == 0) tick();
      end
      if (!fd_sent) apply_stimulus(0, 0, 0, 0, 1, 0);
      wait_frame_written(500, 1);
      tick();
      check_output("random frame drained", exp_q.size(), 0);
      check_output("random frame overflow cleared", overflow, 0);
    end

    repeat (5) tick();
    check_output("final queue empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
